// File: rtl/csa_pipe_adder.sv
// Pipelined carry-select adder; optional subtract mode via CSA_PIPE_SUB_EN (adds sub_i port).
// Latency: STAGES cycles from accept to valid_o; one beat per cycle sustained.
// Backpressure: ready_o ripples combinationally from ready_i back through the stage chain.
module csa_pipe_adder #(
  parameter int WIDTH  = 64,
  parameter int BLOCK  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] num1_i,
  input  logic [WIDTH-1:0] num2_i,
  input  logic             carry_i,
`ifdef CSA_PIPE_SUB_EN
  input  logic             sub_i,
`endif
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  localparam int SEGS = WIDTH / BLOCK;
  localparam int NSEG = SEGS / STAGES;
  localparam logic [BLOCK:0] ONE = (BLOCK+1)'(1);

  // acc holds resolved sum bits below the stage boundary and untouched A bits above it
  typedef struct packed {
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] b;
    logic             c;
  } stage_t;

  stage_t            st_q [STAGES];
  stage_t            st_d [STAGES];
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] unld;
  logic              sub_en;

`ifdef CSA_PIPE_SUB_EN
  assign sub_en = sub_i;
`else
  assign sub_en = 1'b0;
`endif

  // Walk from the output back so each stage sees whether its successor is draining
  always_comb begin : handshake
    logic pass;
    logic vin;
    adv  = '0;
    unld = '0;
    pass = v_q[STAGES-1] & ready_i;
    for (int k = STAGES-1; k >= 0; k--) begin
      vin     = (k == 0) ? valid_i : v_q[(k == 0) ? 0 : k-1];
      unld[k] = pass;
      adv[k]  = vin & (~v_q[k] | pass);
      pass    = adv[k];
    end
  end

  assign ready_o = ~v_q[0] | unld[0];

  always_comb begin : datapath
    stage_t         cur;
    logic [BLOCK:0] s0;
    logic [BLOCK:0] s1;
    logic [BLOCK:0] pick;
    logic           c;
    int             base;
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        cur.acc = num1_i;
        cur.b   = sub_en ? ~num2_i : num2_i;
        cur.c   = sub_en ? 1'b1 : carry_i;
      end else begin
        cur = st_q[(k == 0) ? 0 : k-1];
      end
      c = cur.c;
      for (int s = 0; s < NSEG; s++) begin
        base = (k * NSEG + s) * BLOCK;
        s0   = {1'b0, cur.acc[base +: BLOCK]} + {1'b0, cur.b[base +: BLOCK]};
        s1   = {1'b0, cur.acc[base +: BLOCK]} + {1'b0, cur.b[base +: BLOCK]} + ONE;
        pick = c ? s1 : s0;
        cur.acc[base +: BLOCK] = pick[BLOCK-1:0];
        c = pick[BLOCK];
      end
      cur.c   = c;
      st_d[k] = cur;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      v_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          st_q[k] <= st_d[k];
          v_q[k]  <= 1'b1;
        end else if (unld[k]) begin
          v_q[k]  <= 1'b0;
        end
      end
    end
  end

  assign sum_o   = st_q[STAGES-1].acc;
  assign carry_o = st_q[STAGES-1].c;
  assign valid_o = v_q[STAGES-1];

endmodule
